mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, writeback data width.
REQ-002 SHALL have parameter REG_AW, default 5, destination register index width.
REQ-003 SHALL have parameter CNT_W, default 32, retire counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  MEM stage presents an instruction result.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port RegDst_i  input  REG_AW  destination register index.
REQ-009 SHALL have port RegWEn_i  input  1  register write enable.
REQ-010 SHALL have port data_wb_i  input  DATA_W  writeback data.
REQ-011 SHALL have port flush  input  1  discard all held entries.
REQ-012 SHALL have port out_valid  output  1  WB entry available.
REQ-013 SHALL have port out_ready  input  1  WB/register file consumes the entry.
REQ-014 SHALL have port RegDst_o  output  REG_AW  head entry destination.
REQ-015 SHALL have port RegWEn_o  output  1  head entry write enable, qualified (REQ-024).
REQ-016 SHALL have port data_wb_o  output  DATA_W  head entry data.
REQ-017 SHALL have port fwd_valid  output  1  forwarding candidate valid.
REQ-018 SHALL have port fwd_dst  output  REG_AW  forwarding destination.
REQ-019 SHALL have port fwd_data  output  DATA_W  forwarding data.
REQ-020 SHALL have port retire_cnt  output  CNT_W  count of consumed entries.

Function
REQ-021 SHALL hold up to two entries (head, skid); state EMPTY, ONE, TWO.
REQ-022 SHALL accept when in_valid & in_ready, and pop when out_valid & out_ready.
REQ-023 SHALL drive in_ready = (state != TWO) from registered state only; no combinational path from out_ready to in_ready.
REQ-024 SHALL store RegWEn as RegWEn_i & (RegDst_i != 0); index 0 writes are never issued.
REQ-025 SHALL transition EMPTY->ONE on accept; ONE->TWO on accept without pop; ONE->EMPTY on pop without accept; ONE stays ONE on accept+pop (new entry becomes head); TWO->ONE on pop (skid moves to head); TWO->TWO otherwise.
REQ-026 SHALL drive out_valid = (state != EMPTY); head outputs come from registers, so latency in->out is one cycle.
REQ-027 SHALL keep head outputs stable while out_valid & ~out_ready.
REQ-028 SHALL preserve FIFO order; no entry dropped or duplicated except by flush/rst.
REQ-029 SHALL, on flush, go to EMPTY next cycle; flush outranks a simultaneous accept (input dropped) and pop (pop still counts, REQ-031).
REQ-030 SHALL drive fwd_valid = out_valid & RegWEn_o, fwd_dst = RegDst_o, fwd_data = data_wb_o (head entry only).
REQ-031 SHALL increment retire_cnt by 1 per pop, wrapping modulo 2^CNT_W; flush does not clear it.
REQ-032 SHALL leave data fields of empty slots don't-care but RegWEn of empty slots 0.

Reset
REQ-033 SHALL, while rst=1 at a rising edge, set state EMPTY, all output registers and retire_cnt to 0; rst outranks flush, accept, pop.
REQ-034 SHALL drive in_ready=1, out_valid=0, fwd_valid=0 in the first cycle after rst deasserts.
REQ-035 SHALL discard held entries on rst asserted mid-operation without any pop being counted.

Verification
REQ-036 Single pass: accept {dst=5,wen=1,data=0xDEADBEEF}, out_ready=1 -> next cycle out_valid=1, same fields, fwd_valid=1, fwd_dst=5; following cycle retire_cnt=1.
REQ-037 Backpressure: out_ready=0, push A=0x11, B=0x22 -> in_ready=0 after B, head A stable; raise out_ready -> A then B on consecutive cycles, in_ready=1 after A pops, retire_cnt=2.
REQ-038 x0 suppression: accept {dst=0,wen=1,data=0x5} -> RegWEn_o=0, fwd_valid=0, out_valid=1, still counted on pop.
REQ-039 Flush in TWO with simultaneous in_valid for C=0x33 -> next cycle out_valid=0, in_ready=1, C never appears; retire_cnt unchanged.
REQ-040 Throughput: in_valid=1 and out_ready=1 for 100 cycles with data=cycle index -> 100 outputs in order, one per cycle, state stays ONE.
REQ-041 Counter wrap with CNT_W=4: 17 pops -> retire_cnt=1; rst mid-stream in TWO -> retire_cnt=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline boundary: a two-entry (head + skid) elastic buffer with
// x0 write suppression, head-entry forwarding and a wrapping retire counter.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] RegDst_i,
    input  logic              RegWEn_i,
    input  logic [DATA_W-1:0] data_wb_i,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] RegDst_o,
    output logic              RegWEn_o,
    output logic [DATA_W-1:0] data_wb_o,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_dst,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [REG_AW-1:0]   head_dst_q, head_dst_d, skid_dst_q, skid_dst_d;
    logic                head_wen_q, head_wen_d, skid_wen_q, skid_wen_d;
    logic [DATA_W-1:0]   head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [CNT_W-1:0]    retire_q, retire_d;

    logic accept_s;
    logic pop_s;
    logic wen_in_s;

    assign in_ready   = (state_q != ST_TWO);
    assign out_valid  = (state_q != ST_EMPTY);
    assign accept_s   = in_valid & in_ready;
    assign pop_s      = out_valid & out_ready;
    // Writes to register 0 are stripped on entry so they never reach WB or forwarding.
    assign wen_in_s   = RegWEn_i & (RegDst_i != {REG_AW{1'b0}});

    assign RegDst_o   = head_dst_q;
    assign RegWEn_o   = head_wen_q;
    assign data_wb_o  = head_data_q;
    assign fwd_valid  = out_valid & head_wen_q;
    assign fwd_dst    = head_dst_q;
    assign fwd_data   = head_data_q;
    assign retire_cnt = retire_q;

    // Next-state and slot contents; flush takes priority over accept and pop.
    always_comb begin
        state_d     = state_q;
        head_dst_d  = head_dst_q;
        head_wen_d  = head_wen_q;
        head_data_d = head_data_q;
        skid_dst_d  = skid_dst_q;
        skid_wen_d  = skid_wen_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d    = ST_EMPTY;
            head_wen_d = 1'b0;
            skid_wen_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_dst_d  = RegDst_i;
                        head_wen_d  = wen_in_s;
                        head_data_d = data_wb_i;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        head_dst_d  = RegDst_i;
                        head_wen_d  = wen_in_s;
                        head_data_d = data_wb_i;
                    end else if (accept_s) begin
                        skid_dst_d  = RegDst_i;
                        skid_wen_d  = wen_in_s;
                        skid_data_d = data_wb_i;
                        state_d     = ST_TWO;
                    end else if (pop_s) begin
                        head_wen_d = 1'b0;
                        state_d    = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        head_dst_d  = skid_dst_q;
                        head_wen_d  = skid_wen_q;
                        head_data_d = skid_data_q;
                        skid_wen_d  = 1'b0;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    head_wen_d = 1'b0;
                    skid_wen_d = 1'b0;
                end
            endcase
        end
    end

    // Retire counter: a pop counts even when flush discards the rest.
    always_comb begin
        if (pop_s) begin
            retire_d = retire_q + CNT_W'(1);
        end else begin
            retire_d = retire_q;
        end
    end

    // State and slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_dst_q  <= {REG_AW{1'b0}};
            head_wen_q  <= 1'b0;
            head_data_q <= {DATA_W{1'b0}};
            skid_dst_q  <= {REG_AW{1'b0}};
            skid_wen_q  <= 1'b0;
            skid_data_q <= {DATA_W{1'b0}};
            retire_q    <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            head_dst_q  <= head_dst_d;
            head_wen_q  <= head_wen_d;
            head_data_q <= head_data_d;
            skid_dst_q  <= skid_dst_d;
            skid_wen_q  <= skid_wen_d;
            skid_data_q <= skid_data_d;
            retire_q    <= retire_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a queue-based model checked every cycle,
// plus literal expectations from the worked scenarios.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, RegWEn_i, flush, out_ready;
    logic [4:0]  RegDst_i;
    logic [31:0] data_wb_i;

    logic        in_ready, out_valid, RegWEn_o, fwd_valid;
    logic [4:0]  RegDst_o, fwd_dst;
    logic [31:0] data_wb_o, fwd_data, retire_cnt;

    logic        in_ready4, out_valid4, RegWEn_o4, fwd_valid4;
    logic [4:0]  RegDst_o4, fwd_dst4;
    logic [31:0] data_wb_o4, fwd_data4;
    logic [3:0]  retire_cnt4;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .RegDst_i(RegDst_i), .RegWEn_i(RegWEn_i), .data_wb_i(data_wb_i),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RegDst_o(RegDst_o), .RegWEn_o(RegWEn_o), .data_wb_o(data_wb_o),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .retire_cnt(retire_cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .RegDst_i(RegDst_i), .RegWEn_i(RegWEn_i), .data_wb_i(data_wb_i),
        .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
        .RegDst_o(RegDst_o4), .RegWEn_o(RegWEn_o4), .data_wb_o(data_wb_o4),
        .fwd_valid(fwd_valid4), .fwd_dst(fwd_dst4), .fwd_data(fwd_data4),
        .retire_cnt(retire_cnt4)
    );

    typedef struct {
        logic [4:0]  dst;
        logic        wen;
        logic [31:0] data;
    } entry_t;

    entry_t      q[$];
    int unsigned m_cnt;
    bit          model_ok = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model state for the current cycle.
    task automatic compare();
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("retire_cnt", {32'd0, retire_cnt}, {32'd0, m_cnt});
        chk("retire_cnt4", {60'd0, retire_cnt4}, {60'd0, m_cnt[3:0]});
        if (q.size() > 0) begin
            chk("RegDst_o", {59'd0, RegDst_o}, {59'd0, q[0].dst});
            chk("data_wb_o", {32'd0, data_wb_o}, {32'd0, q[0].data});
            chk("RegWEn_o", {63'd0, RegWEn_o}, {63'd0, q[0].wen});
            chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, q[0].wen});
            chk("fwd_dst", {59'd0, fwd_dst}, {59'd0, q[0].dst});
            chk("fwd_data", {32'd0, fwd_data}, {32'd0, q[0].data});
        end else begin
            chk("RegWEn_o_empty", {63'd0, RegWEn_o}, 64'd0);
            chk("fwd_valid_empty", {63'd0, fwd_valid}, 64'd0);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic v, input logic [4:0] d, input logic w,
                        input logic [31:0] dat, input logic ordy,
                        input logic fl, input logic r);
        bit     do_pop, do_acc;
        entry_t e;
        in_valid = v; RegDst_i = d; RegWEn_i = w; data_wb_i = dat;
        out_ready = ordy; flush = fl; rst = r;
        @(negedge clk);
        if (model_ok) compare();
        @(posedge clk);
        if (r) begin
            q.delete();
            m_cnt    = 0;
            model_ok = 1'b1;
        end else begin
            do_pop = (q.size() > 0) && ordy;
            do_acc = v && (q.size() < 2);
            if (do_pop) m_cnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_acc) begin
                    e.dst  = d;
                    e.wen  = w && (d != 5'd0);
                    e.data = dat;
                    q.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 5'd0, 1'b0, 32'd0, ordy, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] dat, input logic ordy);
        step(1'b1, d, 1'b1, dat, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; RegDst_i = 5'd0; RegWEn_i = 1'b0;
        data_wb_i = 32'd0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        // Reset state
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        chk("rst_data", {32'd0, data_wb_o}, 64'd0);
        chk("rst_retire", {32'd0, retire_cnt}, 64'd0);
        idle(1'b0);

        // Single pass
        push(5'd5, 32'hDEADBEEF, 1'b1);
        chk("sp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("sp_data", {32'd0, data_wb_o}, 64'hDEADBEEF);
        chk("sp_fwd_valid", {63'd0, fwd_valid}, 64'd1);
        chk("sp_fwd_dst", {59'd0, fwd_dst}, 64'd5);
        idle(1'b1);
        chk("sp_retire", {32'd0, retire_cnt}, 64'd1);

        // Backpressure
        push(5'd3, 32'h11, 1'b0);
        push(5'd4, 32'h22, 1'b0);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_head", {32'd0, data_wb_o}, 64'h11);
        idle(1'b0);
        chk("bp_head_stable", {32'd0, data_wb_o}, 64'h11);
        idle(1'b1);
        chk("bp_second", {32'd0, data_wb_o}, 64'h22);
        chk("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
        idle(1'b1);
        chk("bp_retire", {32'd0, retire_cnt}, 64'd3);

        // Register 0 write suppression
        push(5'd0, 32'h5, 1'b0);
        chk("x0_wen", {63'd0, RegWEn_o}, 64'd0);
        chk("x0_fwd", {63'd0, fwd_valid}, 64'd0);
        chk("x0_out_valid", {63'd0, out_valid}, 64'd1);
        idle(1'b1);
        chk("x0_retire", {32'd0, retire_cnt}, 64'd4);

        // Flush in TWO with a competing input, then flush alongside a pop
        push(5'd6, 32'h44, 1'b0);
        push(5'd7, 32'h55, 1'b0);
        step(1'b1, 5'd8, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        chk("fl_retire", {32'd0, retire_cnt}, 64'd4);
        idle(1'b1);
        push(5'd9, 32'h66, 1'b1);
        step(1'b1, 5'd10, 1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        chk("flpop_retire", {32'd0, retire_cnt}, 64'd5);
        chk("flpop_out_valid", {63'd0, out_valid}, 64'd0);

        // Streaming throughput
        for (int i = 0; i < 100; i++) begin
            push(5'(i), 32'(i), 1'b1);
            if (i > 0) chk("tp_data", {32'd0, data_wb_o}, 64'(i));
        end
        idle(1'b1);
        chk("tp_retire", {32'd0, retire_cnt}, 64'd105);

        // Mixed handshake pattern
        for (int i = 0; i < 40; i++) begin
            step((i % 2) == 0 || (i % 7) == 3, 5'(i + 1), (i % 5) != 0,
                 32'hA000 + 32'(i), (i % 3) != 0, i == 25, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Counter wrap on the 4-bit instance, then reset while holding two
        step(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) push(5'd1, 32'(i), 1'b1);
        idle(1'b1);
        chk("wrap_retire4", {60'd0, retire_cnt4}, 64'd1);
        chk("wrap_retire", {32'd0, retire_cnt}, 64'd17);
        push(5'd2, 32'h88, 1'b0);
        push(5'd3, 32'h99, 1'b0);
        chk("pre_rst_in_ready", {63'd0, in_ready}, 64'd0);
        step(1'b1, 5'd4, 1'b1, 32'hAA, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_retire", {32'd0, retire_cnt}, 64'd0);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
